// File: rtl/quad_gray_decoder.sv
// quad_gray_decoder
//   Receive side of the board's Gray-code LED link / rotary encoder input.
//   Two asynchronous Gray bits are synchronized, glitch-filtered and decoded
//   into a signed-step position counter with a sticky illegal-transition flag.
//
//   Parameters
//     BITS    position counter width (count wraps modulo 2^BITS)
//     FILTER  stable cycles needed before a new input value is accepted (1..255)
//
//   Ports
//     clk      system clock
//     resetn   asynchronous active-low reset
//     enc_a    Gray bit 1 (MSB), asynchronous
//     enc_b    Gray bit 0, asynchronous
//     enc_z    index pulse, asynchronous (only when QDEC_INDEX_EN is defined)
//     err_clr  synchronous clear of err
//     count    position, modulo 2^BITS
//     dir      direction of the last legal step, 1 = up
//     step     one-cycle pulse per accepted legal step
//     err      sticky illegal-transition flag
//
//   Build option: define QDEC_INDEX_EN to add enc_z. A filtered 0->1 edge of
//   enc_z zeroes count (the clear beats a coincident step). Ignored in INIT.

// Per-input channel: 2-FF synchronizer followed by a run-length filter.
// cnt holds how many consecutive samples of sync equalled cand, including
// the sample that loaded cand, so a value that sits on sync for FILTER
// cycles raises hit on exactly the edge that completes the FILTERth sample.
// Once saturated at FILTER the run stays quiet until the value changes.
module qgd_chan #(
  parameter int W      = 2,
  parameter int FILTER = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] raw,
  output logic [W-1:0] sync,
  output logic         hit
);
  localparam int            CW   = $clog2(FILTER + 1);
  localparam logic [CW-1:0] FMAX = CW'(FILTER);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [W-1:0]  s1, cand;
  logic [CW-1:0] cnt, run_nxt;
  logic          same;

  assign same = (sync == cand);

  always_comb begin
    run_nxt = ONE;
    if (same) run_nxt = (cnt < FMAX) ? cnt + ONE : cnt;
  end

  // Fires once per stable run: either the run just climbed to FILTER, or
  // FILTER is 1 and a fresh value arrived.
  assign hit = (run_nxt == FMAX) && (!same || cnt != FMAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1   <= '0;
      sync <= '0;
      cand <= '0;
      cnt  <= '0;
    end else begin
      s1   <= raw;
      sync <= s1;
      cand <= sync;
      cnt  <= run_nxt;
    end
  end
endmodule

module quad_gray_decoder #(
  parameter int BITS   = 8,
  parameter int FILTER = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            enc_a,
  input  logic            enc_b,
`ifdef QDEC_INDEX_EN
  input  logic            enc_z,
`endif
  input  logic            err_clr,
  output logic [BITS-1:0] count,
  output logic            dir,
  output logic            step,
  output logic            err
);
  localparam logic            ST_INIT  = 1'b0;
  localparam logic            ST_TRACK = 1'b1;
  localparam logic [BITS-1:0] ONE      = BITS'(1);

  logic       state;
  logic [1:0] ab_sync, acc;
  logic       ab_hit, accept, track_acc;
  logic [1:0] pos_old, pos_new, delta;
  logic       up, dn, bad;
  logic       z_clr;

  qgd_chan #(.W(2), .FILTER(FILTER)) u_ab (
    .clk    (clk),
    .resetn (resetn),
    .raw    ({enc_a, enc_b}),
    .sync   (ab_sync),
    .hit    (ab_hit)
  );

  // In INIT any stable value is learned, even one equal to the reset acc.
  assign accept    = ab_hit && (state == ST_INIT || ab_sync != acc);
  assign track_acc = accept && (state == ST_TRACK);

  // Gray -> binary position: {g1, g1^g0}; the step is the mod-4 difference.
  assign pos_old = {acc[1], ^acc};
  assign pos_new = {ab_sync[1], ^ab_sync};
  assign delta   = pos_new - pos_old;

  assign up  = track_acc && (delta == 2'd1);
  assign dn  = track_acc && (delta == 2'd3);
  assign bad = track_acc && (delta == 2'd2);

`ifdef QDEC_INDEX_EN
  logic z_sync, z_hit, z_acc;

  qgd_chan #(.W(1), .FILTER(FILTER)) u_z (
    .clk    (clk),
    .resetn (resetn),
    .raw    (enc_z),
    .sync   (z_sync),
    .hit    (z_hit)
  );

  // z level is learned in INIT too, so an index held across INIT does not
  // zero the counter the moment tracking starts.
  assign z_clr = z_hit && z_sync && !z_acc && (state == ST_TRACK);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                     z_acc <= 1'b0;
    else if (z_hit && z_sync != z_acc) z_acc <= z_sync;
  end
`else
  assign z_clr = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_INIT;
      acc   <= 2'b00;
      count <= '0;
      dir   <= 1'b0;
      step  <= 1'b0;
      err   <= 1'b0;
    end else begin
      step <= up || dn;
      if (accept) begin
        acc   <= ab_sync;
        state <= ST_TRACK;
      end
      if (z_clr)   count <= '0;
      else if (up) count <= count + ONE;
      else if (dn) count <= count - ONE;
      if (up)      dir <= 1'b1;
      else if (dn) dir <= 1'b0;
      // Set beats a same-cycle clear.
      if (bad)          err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end
endmodule
